// File: rtl/md_sched_if.sv
// md_sched_if -- E/D-stage connection to the multiply/divide sequencer.
//
// Groups the stage-facing signals of md_sched. Clock and reset stay plain
// ports on the sequencer.
//   intReq     flush; the op presented in E this cycle is discarded
//   E_start    E-stage op valid
//   E_mdOp     op code (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//              6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU)
//   E_rs/E_rt  operands A and B (E_rs also carries MTHI/MTLO data)
//   D_isMD     D-stage instruction touches HI/LO
//   E_mdBusy   sequencer occupied
//   D_mdStall  stall request for the D stage
//   HI/LO      architectural HI/LO registers
// Modports: master = pipeline side, slave = sequencer side.
interface md_sched_if;
  logic        intReq;
  logic        E_start;
  logic [3:0]  E_mdOp;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_isMD;
  logic        E_mdBusy;
  logic        D_mdStall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output intReq, E_start, E_mdOp, E_rs, E_rt, D_isMD,
    input  E_mdBusy, D_mdStall, HI, LO
  );

  modport slave (
    input  intReq, E_start, E_mdOp, E_rs, E_rt, D_isMD,
    output E_mdBusy, D_mdStall, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// md_sched -- multi-cycle multiply/divide sequencer for the E stage.
//
// Accepts one MD op per start pulse while idle, latches the operands, stays
// busy for a fixed latency (MULT_CYCLES or DIV_CYCLES) and commits the result
// to HI/LO on the same edge that busy drops. MTHI/MTLO write in one cycle.
// A flush (intReq) in the issue cycle drops the op; a flush during a run does
// not affect it.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   md     md_sched_if.slave (stage handshake, operands, HI/LO, stall)
//
// Parameters: MULT_CYCLES (>=1), DIV_CYCLES (>=1).
// Build option: define MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 7-10);
// otherwise those codes behave as NONE.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // counter only ever holds N-1 .. 0
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [3:0]       opReg;
  logic [31:0]      aReg, bReg;
  logic [31:0]      hiReg, hiNext;
  logic [31:0]      loReg, loNext;
  logic             capture;

  // ---------------- issue-side decode ----------------
  logic isMult, isDiv, isMadd, isLong, canIssue;

  always_comb begin
    isMult = (md.E_mdOp == OP_MULT) || (md.E_mdOp == OP_MULTU);
    isDiv  = (md.E_mdOp == OP_DIV)  || (md.E_mdOp == OP_DIVU);
`ifdef MD_MADD_EN
    isMadd = (md.E_mdOp == OP_MADD) || (md.E_mdOp == OP_MADDU) ||
             (md.E_mdOp == OP_MSUB) || (md.E_mdOp == OP_MSUBU);
`else
    isMadd = 1'b0;
`endif
    isLong   = isMult | isDiv | isMadd;
    canIssue = md.E_start & ~md.intReq & (stateReg == IDLE);
  end

  // ---------------- arithmetic on latched operands ----------------
  logic        opSigned;
  logic [32:0] aExt, bExt;
  logic [63:0] prod;
  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag, bSafe, qMag, rMag, quot, rem;

  always_comb begin
    opSigned = (opReg == OP_MULT) || (opReg == OP_DIV) ||
               (opReg == OP_MADD) || (opReg == OP_MSUB);
    // 33-bit extension lets one signed multiplier serve both signednesses
    aExt = {opSigned & aReg[31], aReg};
    bExt = {opSigned & bReg[31], bReg};
    prod = $signed(aExt) * $signed(bExt);

    // Divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000/-1 falls out as 0x80000000
    // because its magnitude wraps back to itself on negation.
    aNeg  = opSigned & aReg[31];
    bNeg  = opSigned & bReg[31];
    aMag  = aNeg ? (32'd0 - aReg) : aReg;
    bMag  = bNeg ? (32'd0 - bReg) : bReg;
    bSafe = (bReg == 32'd0) ? 32'd1 : bMag;  // result discarded when divisor is 0
    qMag  = aMag / bSafe;
    rMag  = aMag % bSafe;
    quot  = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
    rem   = aNeg ? (32'd0 - rMag) : rMag;
  end

  // ---------------- next-state / datapath control ----------------
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    hiNext    = hiReg;
    loNext    = loReg;
    capture   = 1'b0;

    unique case (stateReg)
      IDLE: begin
        if (canIssue) begin
          if (isLong) begin
            stateNext = RUN;
            cntNext   = isDiv ? DIV_LOAD : MULT_LOAD;
            capture   = 1'b1;
          end else if (md.E_mdOp == OP_MTHI) begin
            hiNext = md.E_rs;
          end else if (md.E_mdOp == OP_MTLO) begin
            loNext = md.E_rs;
          end
        end
      end
      RUN: begin
        if (cntReg == '0) begin
          stateNext = IDLE;
          unique case (opReg)
            OP_MULT, OP_MULTU: {hiNext, loNext} = prod;
            OP_DIV, OP_DIVU: begin
              if (bReg != 32'd0) begin
                loNext = quot;
                hiNext = rem;
              end
            end
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: {hiNext, loNext} = {hiReg, loReg} + prod;
            OP_MSUB, OP_MSUBU: {hiNext, loNext} = {hiReg, loReg} - prod;
`endif
            default: ;
          endcase
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      opReg    <= 4'd0;
      aReg     <= 32'd0;
      bReg     <= 32'd0;
      hiReg    <= 32'd0;
      loReg    <= 32'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      hiReg    <= hiNext;
      loReg    <= loNext;
      if (capture) begin
        opReg <= md.E_mdOp;
        aReg  <= md.E_rs;
        bReg  <= md.E_rt;
      end
    end
  end

  // ---------------- outputs ----------------
  assign md.E_mdBusy  = (stateReg == RUN);
  // stall also covers the issue cycle so D cannot slip past a starting op
  assign md.D_mdStall = reset & md.D_isMD & ((stateReg == RUN) | (md.E_start & isLong));
  assign md.HI        = hiReg;
  assign md.LO        = loReg;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched -- directed self-checking bench for md_sched
// (MULT_CYCLES=5, DIV_CYCLES=10). Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sched_if mdIf();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdIf.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdIf.E_start = 1'b1;
    mdIf.E_mdOp  = op;
    mdIf.E_rs    = a;
    mdIf.E_rt    = b;
    tick();
    mdIf.E_start = 1'b0;
    mdIf.E_mdOp  = 4'd0;
  endtask

  // counts busy cycles after the issue edge, bounded
  task automatic waitIdle(output int n);
    n = 0;
    while (mdIf.E_mdBusy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int expCycles,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    issue(op, a, b);
    waitIdle(n);
    $display("txn %s op=%0d a=0x%08h b=0x%08h busyCycles=%0d HI=0x%08h LO=0x%08h",
             tag, op, a, b, n, mdIf.HI, mdIf.LO);
    check({tag, "_cycles"}, 32'(n), 32'(expCycles));
    check({tag, "_hi"}, mdIf.HI, expHi);
    check({tag, "_lo"}, mdIf.LO, expLo);
  endtask

  initial begin
    int n;
    reset        = 1'b0;
    mdIf.intReq  = 1'b0;
    mdIf.E_start = 1'b1;
    mdIf.E_mdOp  = 4'd1;
    mdIf.E_rs    = 32'd0;
    mdIf.E_rt    = 32'd0;
    mdIf.D_isMD  = 1'b1;
    #2;
    // reset state, stall forced low even with a stall-worthy request present
    check("rst_busy",  32'(mdIf.E_mdBusy), 32'd0);
    check("rst_stall", 32'(mdIf.D_mdStall), 32'd0);
    check("rst_hi", mdIf.HI, 32'd0);
    check("rst_lo", mdIf.LO, 32'd0);
    mdIf.E_start = 1'b0;
    mdIf.E_mdOp  = 4'd0;
    mdIf.D_isMD  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // preload HI/LO
    issue(4'd5, 32'hDEADBEEF, 32'd0);
    $display("txn mthi HI=0x%08h", mdIf.HI);
    check("mthi_pre_hi", mdIf.HI, 32'hDEADBEEF);
    check("mthi_pre_busy", 32'(mdIf.E_mdBusy), 32'd0);
    issue(4'd6, 32'h12345678, 32'd0);
    $display("txn mtlo LO=0x%08h", mdIf.LO);
    check("mtlo_pre_lo", mdIf.LO, 32'h12345678);

    // 1: reset mid-DIV (cnt=4 after edge 5)
    issue(4'd3, 32'd100, 32'd7);
    repeat (5) tick();
    check("middiv_busy", 32'(mdIf.E_mdBusy), 32'd1);
    reset = 1'b0;
    #1;
    $display("txn reset_mid_div busy=%0d HI=0x%08h LO=0x%08h", mdIf.E_mdBusy, mdIf.HI, mdIf.LO);
    check("midrst_busy", 32'(mdIf.E_mdBusy), 32'd0);
    check("midrst_hi", mdIf.HI, 32'd0);
    check("midrst_lo", mdIf.LO, 32'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    check("postrst_busy", 32'(mdIf.E_mdBusy), 32'd0);
    check("postrst_hi", mdIf.HI, 32'd0);
    check("postrst_lo", mdIf.LO, 32'd0);

    // 2: MULT / MULTU
    runOp("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runOp("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);

    // 3: DIV / DIVU
    runOp("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    runOp("divu_zero", 4'd4, 32'd5, 32'd0, 10, 32'h00000000, 32'h80000000);

    // operands changing mid-op must not affect the result
    issue(4'd4, 32'd100, 32'd7);
    mdIf.E_rs = 32'h0000FFFF;
    mdIf.E_rt = 32'd3;
    waitIdle(n);
    $display("txn divu_hold busyCycles=%0d HI=0x%08h LO=0x%08h", n, mdIf.HI, mdIf.LO);
    check("divu_hold_cycles", 32'(n), 32'd10);
    check("divu_hold_hi", mdIf.HI, 32'd2);
    check("divu_hold_lo", mdIf.LO, 32'd14);

    // 4: stall on start cycle and all busy cycles
    mdIf.D_isMD  = 1'b1;
    mdIf.E_start = 1'b1;
    mdIf.E_mdOp  = 4'd5;
    #1;
    check("stall_mthi", 32'(mdIf.D_mdStall), 32'd0);
    mdIf.E_start = 1'b0;
    mdIf.E_mdOp  = 4'd0;
    mdIf.E_start = 1'b1;
    mdIf.E_mdOp  = 4'd1;
    mdIf.E_rs    = 32'd3;
    mdIf.E_rt    = 32'd4;
    #1;
    check("stall_start", 32'(mdIf.D_mdStall), 32'd1);
    tick();
    mdIf.E_start = 1'b0;
    mdIf.E_mdOp  = 4'd0;
    n = 0;
    while (mdIf.E_mdBusy === 1'b1 && n < 200) begin
      check("stall_busy", 32'(mdIf.D_mdStall), 32'd1);
      n++;
      tick();
    end
    $display("txn mult_stall busyCycles=%0d stall=%0d LO=0x%08h", n, mdIf.D_mdStall, mdIf.LO);
    check("stall_cycles", 32'(n), 32'd5);
    check("stall_after", 32'(mdIf.D_mdStall), 32'd0);
    check("stall_mult_lo", mdIf.LO, 32'd12);
    check("stall_mult_hi", mdIf.HI, 32'd0);
    mdIf.D_isMD = 1'b0;

    // 5: flush behaviour
    mdIf.intReq = 1'b1;
    issue(4'd5, 32'h00001234, 32'd0);
    mdIf.intReq = 1'b0;
    $display("txn mthi_flushed HI=0x%08h", mdIf.HI);
    check("mthi_flush_hi", mdIf.HI, 32'd0);
    issue(4'd5, 32'h00001234, 32'd0);
    $display("txn mthi HI=0x%08h", mdIf.HI);
    check("mthi_hi", mdIf.HI, 32'h00001234);
    check("mthi_busy", 32'(mdIf.E_mdBusy), 32'd0);

    mdIf.intReq = 1'b1;
    issue(4'd1, 32'd5, 32'd5);
    mdIf.intReq = 1'b0;
    $display("txn mult_flushed busy=%0d LO=0x%08h", mdIf.E_mdBusy, mdIf.LO);
    check("mult_flush_busy", 32'(mdIf.E_mdBusy), 32'd0);
    tick();
    check("mult_flush_lo", mdIf.LO, 32'd12);

    issue(4'd1, 32'd7, 32'd6);
    mdIf.intReq = 1'b1;
    waitIdle(n);
    mdIf.intReq = 1'b0;
    $display("txn mult_intrun busyCycles=%0d HI=0x%08h LO=0x%08h", n, mdIf.HI, mdIf.LO);
    check("mult_int_cycles", 32'(n), 32'd5);
    check("mult_int_hi", mdIf.HI, 32'd0);
    check("mult_int_lo", mdIf.LO, 32'd42);

    // 6: multiply-accumulate ops
`ifdef MD_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd1, 32'd0);
    runOp("madd",  4'd7,  32'd2, 32'd3, 5, 32'h00000000, 32'h00000007);
    runOp("msubu", 4'd10, 32'd1, 32'd8, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    mdIf.D_isMD  = 1'b1;
    mdIf.E_start = 1'b1;
    mdIf.E_mdOp  = 4'd7;
    mdIf.E_rs    = 32'd2;
    mdIf.E_rt    = 32'd3;
    #1;
    check("op7_stall", 32'(mdIf.D_mdStall), 32'd0);
    tick();
    mdIf.E_start = 1'b0;
    mdIf.E_mdOp  = 4'd0;
    mdIf.D_isMD  = 1'b0;
    $display("txn op7_disabled busy=%0d HI=0x%08h LO=0x%08h", mdIf.E_mdBusy, mdIf.HI, mdIf.LO);
    check("op7_busy", 32'(mdIf.E_mdBusy), 32'd0);
    repeat (6) tick();
    check("op7_hi", mdIf.HI, 32'd0);
    check("op7_lo", mdIf.LO, 32'd42);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
